// File: rtl/rv32i_types.sv
// +----------------------------------------------------------------------------+
// | rv32i_types : shared types and constants for the rv32i core               |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package rv32i_types;

    typedef logic [255:0] cache_line_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    localparam int c_OFFSET_BITS   = 5;
    localparam int c_WORD_SEL_BITS = 3;

endpackage

`default_nettype wire

// File: rtl/icache_control.sv
// +----------------------------------------------------------------------------+
// | icache_control : IDLE/FILL sequencer for the instruction cache            |
// | Revision       : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module icache_control
    import rv32i_types::*;
(
    input  logic clk,
    input  logic reset,
    input  logic read_a,
    input  logic hit,
    input  logic pmem_resp,
    output logic resp_a,
    output logic pmem_read,
    output logic fill_start,
    output logic load
);

    icache_state_t r_state;
    icache_state_t w_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        resp_a     = 1'b0;
        pmem_read  = 1'b0;
        fill_start = 1'b0;
        load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (read_a) begin
                    if (hit) begin
                        resp_a = 1'b1;
                    end else begin
                        fill_start = 1'b1;
                        w_next     = FILL;
                    end
                end
            end
            FILL: begin
                pmem_read = 1'b1;
                // The request is looked up again in IDLE, so no response here.
                if (pmem_resp) begin
                    load   = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/icache.sv
// +----------------------------------------------------------------------------+
// | icache   : direct-mapped read-only instruction cache on the fetch port    |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module icache
    import rv32i_types::*;
#(
    parameter int NUM_SETS  = 8,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read_a,
    input  logic [31:0]          address_a,
    output logic [31:0]          rdata_a,
    output logic                 resp_a,
    output logic                 pmem_read,
    output logic [31:0]          pmem_address,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
);

    localparam int c_INDEX_BITS = $clog2(NUM_SETS);
    localparam int c_TAG_BITS   = 32 - c_OFFSET_BITS - c_INDEX_BITS;
    localparam int c_LINE_ADDR  = 32 - c_OFFSET_BITS;
    localparam int c_WORDS      = 1 << c_WORD_SEL_BITS;

    logic [NUM_SETS-1:0]     r_valid;
    logic [c_TAG_BITS-1:0]   r_tag  [NUM_SETS];
    cache_line_t             r_data [NUM_SETS];
    logic [c_LINE_ADDR-1:0]  r_fill_line;

    logic [c_INDEX_BITS-1:0]    w_index;
    logic [c_TAG_BITS-1:0]      w_tag;
    logic [c_WORD_SEL_BITS-1:0] w_word;
    logic [c_INDEX_BITS-1:0]    w_fill_index;
    logic [c_TAG_BITS-1:0]      w_fill_tag;
    logic                       w_hit;
    logic                       w_fill_start;
    logic                       w_load;
    cache_line_t                w_line;
    logic [31:0]                w_words [c_WORDS];
    logic                       w_unused_addr;

    assign w_index       = address_a[c_OFFSET_BITS +: c_INDEX_BITS];
    assign w_tag         = address_a[31 -: c_TAG_BITS];
    assign w_word        = address_a[2 +: c_WORD_SEL_BITS];
    assign w_unused_addr = ^address_a[1:0];

    // Fills are steered by the address captured at miss time, never the live one.
    assign w_fill_index = r_fill_line[c_INDEX_BITS-1:0];
    assign w_fill_tag   = r_fill_line[c_LINE_ADDR-1 -: c_TAG_BITS];
    assign pmem_address = {r_fill_line, {c_OFFSET_BITS{1'b0}}};

    assign w_hit  = read_a & r_valid[w_index] & (r_tag[w_index] == w_tag);
    assign w_line = r_data[w_index];

    for (genvar gi = 0; gi < c_WORDS; gi++) begin : g_words
        assign w_words[gi] = w_line[32*gi +: 32];
    end

    assign rdata_a = w_words[w_word];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (w_load) begin
            r_valid[w_fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_load && !reset) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= pmem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fill_line <= '0;
        end else if (w_fill_start) begin
            r_fill_line <= address_a[31:c_OFFSET_BITS];
        end
    end

    icache_control u_control (
        .clk        (clk),
        .reset      (reset),
        .read_a     (read_a),
        .hit        (w_hit),
        .pmem_resp  (pmem_resp),
        .resp_a     (resp_a),
        .pmem_read  (pmem_read),
        .fill_start (w_fill_start),
        .load       (w_load)
    );

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// +----------------------------------------------------------------------------+
// | tb_icache : self-checking bench for icache against a line-level model     |
// | Revision  : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_icache;

    localparam int c_SETS = 8;

    logic         clk;
    logic         reset;
    logic         read_a;
    logic [31:0]  address_a;
    logic [31:0]  rdata_a;
    logic         resp_a;
    logic         pmem_read;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int n_checks;
    int n_errors;

    // Reference cache contents: which memory line each set currently holds.
    logic        m_valid [c_SETS];
    logic [26:0] m_line  [c_SETS];

    icache #(
        .NUM_SETS  (c_SETS),
        .LINE_BITS (256)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .read_a       (read_a),
        .address_a    (address_a),
        .rdata_a      (rdata_a),
        .resp_a       (resp_a),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [26:0] line, input int w);
        return 32'h1000_0000 + ((32'(line) - 32'd2) << 8) + 32'(w);
    endfunction

    function automatic logic [255:0] line_data(input logic [26:0] line);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = mem_word(line, i);
        return d;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int idx;
        idx = int'(a[7:5]);
        return m_valid[idx] && (m_line[idx] == a[31:5]);
    endfunction

    // Presents one fetch, plays memory with a k-cycle reply delay, and
    // returns the cycle (0 = presentation cycle) at which the word came back.
    task automatic fetch(input logic [31:0] addr, input int k, input bit redir,
                         input logic [31:0] raddr, output int lat);
        bit          busy;
        bit          done;
        bit          redir_pending;
        int          pc;
        logic [26:0] fl;
        logic [31:0] cur;
        busy = 0; done = 0; pc = 0; lat = -1; fl = '0;
        redir_pending = redir;
        cur = addr;
        read_a = 1'b1;
        address_a = addr;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            @(negedge clk);
            if (!busy) begin
                if (model_hit(cur)) begin
                    chk("resp_on_hit", 32'(resp_a), 32'd1);
                    chk("rdata", rdata_a, mem_word(cur[31:5], int'(cur[4:2])));
                    chk("pmem_read_on_hit", 32'(pmem_read), 32'd0);
                    lat = cyc;
                    done = 1;
                end else begin
                    chk("resp_on_miss", 32'(resp_a), 32'd0);
                    chk("pmem_read_idle", 32'(pmem_read), 32'd0);
                    busy = 1;
                    pc = 0;
                    fl = cur[31:5];
                end
            end else begin
                pc++;
                chk("resp_in_fill", 32'(resp_a), 32'd0);
                chk("pmem_read_in_fill", 32'(pmem_read), 32'd1);
                chk("pmem_address", pmem_address, {fl, 5'b0});
                if (pc == k + 1) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = line_data(fl);
                    m_valid[int'(fl[2:0])] = 1'b1;
                    m_line[int'(fl[2:0])]  = fl;
                    busy = 0;
                end
            end
            @(posedge clk);
            #1;
            pmem_resp  = 1'b0;
            pmem_rdata = {8{32'hDEAD_BEEF}};
            if (redir_pending && busy && pc == 1) begin
                cur = raddr;
                address_a = raddr;
                redir_pending = 0;
            end
        end
        if (!done) chk("fetch_timeout", 32'd0, 32'd1);
        read_a = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] a;
        logic [31:0] b;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < c_SETS; i++) begin
            m_valid[i] = 1'b0;
            m_line[i]  = '0;
        end
        reset = 1'b1;
        read_a = 1'b0;
        address_a = 32'h0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_resp", 32'(resp_a), 32'd0);
        chk("reset_pmem_read", 32'(pmem_read), 32'd0);
        @(posedge clk);
        #1;

        // Cold miss then hits in the same line.
        fetch(32'h0000_0040, 3, 0, 32'h0, lat);
        chk("cold_latency", 32'(lat), 32'd5);
        fetch(32'h0000_0044, 0, 0, 32'h0, lat);
        chk("hit_latency", 32'(lat), 32'd0);
        fetch(32'h0000_0046, 0, 0, 32'h0, lat);
        chk("hit_low_bits_latency", 32'(lat), 32'd0);

        // Conflicting tags on index 2 evict each other.
        fetch(32'h0000_0140, 1, 0, 32'h0, lat);
        chk("conflict_latency", 32'(lat), 32'd3);
        fetch(32'h0000_0040, 2, 0, 32'h0, lat);
        chk("refill_latency", 32'(lat), 32'd4);

        // Redirect during the fill for 0x40 (index 2 currently holds 0x140).
        fetch(32'h0000_0140, 0, 0, 32'h0, lat);
        fetch(32'h0000_0040, 2, 1, 32'h0000_0144, lat);
        fetch(32'h0000_0040, 0, 0, 32'h0, lat);
        chk("redirect_evicted_latency", 32'(lat), 32'd2);

        // Reset while a fill is outstanding.
        read_a = 1'b1;
        address_a = 32'h0000_0060;
        @(negedge clk);
        chk("rst_fill_miss", 32'(resp_a), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_fill_pmem_read", 32'(pmem_read), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        read_a = 1'b0;
        for (int i = 0; i < c_SETS; i++) m_valid[i] = 1'b0;
        @(negedge clk);
        chk("rst_abort_pmem_read", 32'(pmem_read), 32'd0);
        chk("rst_abort_resp", 32'(resp_a), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        pmem_resp = 1'b1;
        pmem_rdata = line_data(27'h3);
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        fetch(32'h0000_0060, 1, 0, 32'h0, lat);
        chk("post_reset_60_miss", 32'(lat), 32'd3);
        fetch(32'h0000_0044, 1, 0, 32'h0, lat);
        chk("post_reset_40_miss", 32'(lat), 32'd3);

        // Idle cycles with wandering addresses.
        for (int i = 0; i < 10; i++) begin
            read_a = 1'b0;
            address_a = $urandom;
            @(negedge clk);
            chk("idle_resp", 32'(resp_a), 32'd0);
            chk("idle_pmem_read", 32'(pmem_read), 32'd0);
            @(posedge clk);
            #1;
        end

        // Random fetch stream over a small pool of lines with occasional redirects.
        for (int n = 0; n < 60; n++) begin
            a = {22'd0, 3'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            b = {22'd0, 3'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 5) == 0) begin
                fetch(a, int'($urandom_range(1, 3)), 1, b, lat);
            end else begin
                fetch(a, int'($urandom_range(0, 3)), 0, 32'h0, lat);
            end
            repeat (int'($urandom_range(0, 2))) begin
                @(negedge clk);
                chk("gap_resp", 32'(resp_a), 32'd0);
                @(posedge clk);
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache that is the responder on the fetch stage's instruction port (port A). It answers `read_a`/`address_a` with `rdata_a`/`resp_a`: combinationally on a hit, after a line fill from physical memory on a miss. It sits between fetch and the physical-memory arbiter and never writes back.

## Interface
- `NUM_SETS`, 8: number of lines; power of two, at least 2.
- `LINE_BITS`, 256: line width (32 bytes, 8 words); fixed by the pmem bus.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `read_a`  in  1  fetch read request; held until `resp_a`.
- `address_a`  in  32  fetch byte address; `address_a[1:0]` ignored.
- `rdata_a`  out  32  instruction word; valid only while `resp_a`=1.
- `resp_a`  out  1  request served this cycle.
- `pmem_read`  out  1  line-fill request to physical memory.
- `pmem_address`  out  32  line-aligned fill address (low 5 bits zero).
- `pmem_rdata`  in  256  fill data, word i at bits [32i+31:32i].
- `pmem_resp`  in  1  fill data valid; single-cycle pulse.

## Operation
- Address split: offset = `[4:0]`, word select = `[4:2]`, index = `[4+log2(NUM_SETS):5]`, tag = remaining upper bits.
- State per set: valid bit, tag, and a 256-bit line.
- Hit = `read_a` & valid[index] & (tag[index] == address tag).
- FSM states:
  - IDLE:
    - On a hit: `resp_a`=1 and `rdata_a` = the selected word, in the same cycle.
    - On `read_a` & miss: latch the line address; go to FILL.
    - When `read_a`=0: `resp_a`=0 and no action.
  - FILL:
    - `pmem_read`=1; `pmem_address` = latched line address.
    - On `pmem_resp`: write line, tag, and valid for the latched index; go to IDLE.
    - `resp_a`=0 throughout FILL.
- After a fill, the request is re-evaluated in IDLE against the current `address_a`. If fetch changed its address mid-miss (e.g. a branch redirect), the new address hits or misses on its own; the filled line is kept.
- Fill always targets the latched index/tag, never the live `address_a`.
- Replacement: unconditional overwrite of the indexed set (direct-mapped).
- Reset:
  - All valid bits cleared; FSM in IDLE; `pmem_read`=0; `resp_a`=0.
  - Tag and data arrays need not be reset.
- Reset during FILL aborts the fill with no array write. A `pmem_resp` that arrives later, while in IDLE, is ignored.
- `reset` and `pmem_resp` in the same cycle: reset wins, nothing is written.
- `rdata_a` value is don't-care when `resp_a`=0.

## Timing
- Hit latency: 0 cycles (`resp_a` is combinational from `address_a`/`read_a` and the arrays).
- Miss latency: 1 cycle IDLE→FILL, plus N pmem cycles, plus 1 cycle IDLE re-lookup. So `resp_a` arrives at least 2 cycles after `pmem_resp`-1; with `pmem_resp` arriving k cycles after `pmem_read` rises, `resp_a` arrives k+2 cycles after the miss is first presented.
- `pmem_read` is registered-state driven. It rises the cycle after the miss is seen and falls the cycle after `pmem_resp`.
- At most one outstanding fill; no hit-under-miss.
- Valid/tag/data writes take effect at the edge ending the `pmem_resp` cycle and are visible to lookup in the next cycle.

## Structure
- Add to the shared `rv32i_types` package:
  - `cache_line_t` (logic [255:0]);
  - `icache_state_t` enum {IDLE, FILL};
  - offset/word-select width constants.
- Split into two modules:
  - `icache_control`: FSM; drives `pmem_read`, `resp_a`, and the array load enable.
  - `icache` top: arrays, tag compare, word mux, latched fill address.

## Test plan
- **Cold miss:** after reset, `read_a`=1 at 0x0000_0040; pmem replies 3 cycles after `pmem_read` with word i = 0x1000_0000+i.
  - `pmem_address`=0x0000_0040.
  - `resp_a`=1 with `rdata_a`=0x1000_0000, exactly 5 cycles after the request is presented.
- **Hit:** then 0x0000_0044 → `resp_a`=1 in the same cycle, `rdata_a`=0x1000_0001, `pmem_read` stays 0. Address 0x0000_0046 returns the same word.
- **Conflict:** 0x0000_0140 (index 2, new tag) → miss and fill. A following 0x0000_0040 misses again and refills.
- **Redirect mid-miss:** during FILL for 0x40, switch `address_a` to 0x0000_0144 (index 2).
  - The fill completes for line 0x40.
  - A new miss for 0x140 follows.
  - `resp_a` is never asserted with 0x40 data for the 0x144 request.
- **Reset mid-fill:** assert `reset` while `pmem_read`=1.
  - Next cycle `pmem_read`=0 and all sets are invalid.
  - A `pmem_resp` pulse 2 cycles later causes no write; a subsequent read of 0x40 misses.
- **Idle:** `read_a`=0 for 10 cycles with arbitrary addresses → `resp_a`=0 and `pmem_read`=0 throughout.
